// File: rtl/target_score_keeper.sv
// Score keeper for a two-player target-pocket game: tracks turns, scores pots
// one cycle after they are reported, and detects the winner at the end of each shot.
module target_score_keeper #(
    parameter int WIN_SCORE   = 15,
    parameter int PTS_CORRECT = 2,
    parameter int PTS_OTHER   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gameStart,
    input  logic       shotFired,
    input  logic       ballsStopped,
    input  logic       increasePoint,
    input  logic       correctTarget,
    output logic [6:0] score1,
    output logic [6:0] score2,
    output logic       currentPlayer,
    output logic       newTargetReq,
    output logic       gameOver,
    output logic [1:0] winner,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        AIM       = 3'd1,
        ROLL      = 3'd2,
        SETTLE    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t     state;
    logic       pot_pending;
    logic       shot_scored;
    logic       scoring_state;
    logic       win1;
    logic       win2;
    logic [7:0] award;

    assign fsm_state     = state;
    assign scoring_state = (state == AIM) || (state == ROLL) || (state == SETTLE);
    assign award         = correctTarget ? 8'(PTS_CORRECT) : 8'(PTS_OTHER);
    assign win1          = {1'b0, score1} >= 8'(WIN_SCORE);
    assign win2          = {1'b0, score2} >= 8'(WIN_SCORE);

    // 8-bit add so an overflow past 127 is visible before clamping.
    function automatic logic [6:0] sat_add(input logic [6:0] s, input logic [7:0] p);
        logic [7:0] sum;
        sum = {1'b0, s} + p;
        return (sum > 8'd127) ? 7'd127 : sum[6:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            score1        <= '0;
            score2        <= '0;
            currentPlayer <= 1'b0;
            newTargetReq  <= 1'b0;
            gameOver      <= 1'b0;
            winner        <= 2'b00;
            pot_pending   <= 1'b0;
            shot_scored   <= 1'b0;
        end else begin
            pot_pending  <= increasePoint && scoring_state;
            newTargetReq <= pot_pending && correctTarget;

            if (pot_pending) begin
                if (currentPlayer) score2 <= sat_add(score2, award);
                else               score1 <= sat_add(score1, award);
            end

            case (state)
                IDLE: begin
                    if (gameStart) begin
                        state         <= AIM;
                        score1        <= '0;
                        score2        <= '0;
                        currentPlayer <= 1'b0;
                        winner        <= 2'b00;
                    end
                end
                AIM: begin
                    if (shotFired) begin
                        state       <= ROLL;
                        shot_scored <= 1'b0;
                    end
                end
                ROLL: begin
                    if (pot_pending) shot_scored <= 1'b1;
                    // Hold in ROLL until any pot reported now or last cycle is applied.
                    if (ballsStopped && !pot_pending && !increasePoint) state <= SETTLE;
                end
                SETTLE: begin
                    if (win1) begin
                        state    <= GAME_OVER;
                        gameOver <= 1'b1;
                        winner   <= 2'b01;
                    end else if (win2) begin
                        state    <= GAME_OVER;
                        gameOver <= 1'b1;
                        winner   <= 2'b10;
                    end else begin
                        state <= AIM;
                        if (!shot_scored) currentPlayer <= ~currentPlayer;
                    end
                end
                GAME_OVER: begin
                    if (gameStart) begin
                        state         <= AIM;
                        score1        <= '0;
                        score2        <= '0;
                        currentPlayer <= 1'b0;
                        gameOver      <= 1'b0;
                        winner        <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_target_score_keeper.sv
// Directed bench for target_score_keeper: the driver pushes hand-computed output
// snapshots into a queue and a negedge monitor pops and compares them.
module tb_target_score_keeper;

    localparam int W = 22;
    localparam logic [2:0] S_IDLE = 3'd0, S_AIM = 3'd1, S_ROLL = 3'd2,
                           S_SETTLE = 3'd3, S_GO = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       gameStart = 1'b0;
    logic       shotFired = 1'b0;
    logic       ballsStopped = 1'b0;
    logic       increasePoint = 1'b0;
    logic       correctTarget = 1'b0;
    logic [6:0] score1;
    logic [6:0] score2;
    logic       currentPlayer;
    logic       newTargetReq;
    logic       gameOver;
    logic [1:0] winner;
    logic [2:0] fsm_state;

    target_score_keeper dut (
        .clk(clk), .reset(reset), .gameStart(gameStart), .shotFired(shotFired),
        .ballsStopped(ballsStopped), .increasePoint(increasePoint),
        .correctTarget(correctTarget), .score1(score1), .score2(score2),
        .currentPlayer(currentPlayer), .newTargetReq(newTargetReq),
        .gameOver(gameOver), .winner(winner), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // expected model values, set by hand in the stimulus
    logic [6:0] m_s1 = '0, m_s2 = '0;
    logic       m_cur = 1'b0, m_ntr = 1'b0, m_go = 1'b0;
    logic [1:0] m_win = 2'b00;
    logic [2:0] m_st = S_IDLE;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W-1:0] pack(input logic [6:0] s1, input logic [6:0] s2,
                                          input logic cur, input logic ntr, input logic go,
                                          input logic [1:0] win, input logic [2:0] st);
        return {s1, s2, cur, ntr, go, win, st};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        reset = 1'b0; gameStart = 1'b0; shotFired = 1'b0;
        increasePoint = 1'b0; correctTarget = 1'b0;
    endtask

    task automatic chk(input string name);
        exp_q.push_back(pack(m_s1, m_s2, m_cur, m_ntr, m_go, m_win, m_st));
        name_q.push_back(name);
    endtask

    task automatic clear_model();
        m_s1 = '0; m_s2 = '0; m_cur = 1'b0; m_ntr = 1'b0; m_go = 1'b0;
        m_win = 2'b00; m_st = S_IDLE;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] act, exp_v;
        string        nm;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = pack(score1, score2, currentPlayer, newTargetReq, gameOver, winner, fsm_state);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s: got s1=%0d s2=%0d cur=%0b ntr=%0b go=%0b win=%b st=%0d, expected s1=%0d s2=%0d cur=%0b ntr=%0b go=%0b win=%b st=%0d",
                         nm, act[21:15], act[14:8], act[7], act[6], act[5], act[4:3], act[2:0],
                         exp_v[21:15], exp_v[14:8], exp_v[7], exp_v[6], exp_v[5], exp_v[4:3], exp_v[2:0]);
            end
        end
    end

    initial begin
        // reset and idle behaviour
        reset = 1'b1; tick(); clear_model(); chk("reset");
        increasePoint = 1'b1; tick(); tick(); chk("idle_ignores_pot");
        gameStart = 1'b1; tick(); m_st = S_AIM; chk("start");
        shotFired = 1'b1; tick(); m_st = S_ROLL; chk("shot");

        // correct pot by player 1
        increasePoint = 1'b1; tick(); chk("pot_pending_no_score_yet");
        correctTarget = 1'b1; tick(); m_s1 = 7'd2; m_ntr = 1'b1; chk("correct_award");
        ballsStopped = 1'b1; tick(); m_ntr = 1'b0; m_st = S_SETTLE; chk("ntr_single_pulse");
        tick(); m_st = S_AIM; chk("keep_turn_after_pot");
        ballsStopped = 1'b0;

        // miss hands the turn to player 2
        shotFired = 1'b1; tick(); m_st = S_ROLL;
        ballsStopped = 1'b1; tick(); m_st = S_SETTLE; chk("miss_settle");
        tick(); m_st = S_AIM; m_cur = 1'b1; chk("miss_toggle");
        ballsStopped = 1'b0;

        // double pot by player 2: other then correct
        shotFired = 1'b1; tick(); m_st = S_ROLL;
        increasePoint = 1'b1; tick();
        increasePoint = 1'b1; correctTarget = 1'b0; tick(); m_s2 = 7'd1; chk("double_first");
        correctTarget = 1'b1; tick(); m_s2 = 7'd3; m_ntr = 1'b1; chk("double_second");
        tick(); m_ntr = 1'b0; chk("double_one_ntr_pulse");
        ballsStopped = 1'b1; tick(); m_st = S_SETTLE;
        shotFired = 1'b1; tick(); m_st = S_AIM; chk("settle_ignores_shot");
        gameStart = 1'b1; tick(); chk("aim_ignores_start");
        ballsStopped = 1'b0;

        // late stop: balls stop on the pending cycle
        shotFired = 1'b1; tick(); m_st = S_ROLL;
        increasePoint = 1'b1; tick();
        ballsStopped = 1'b1; tick(); m_s2 = 7'd4; chk("late_stop_holds_roll");
        tick(); m_st = S_SETTLE; chk("late_stop_settle");
        tick(); m_st = S_AIM; chk("late_stop_keep_turn");
        ballsStopped = 1'b0;

        // player 2 misses, back to player 1
        shotFired = 1'b1; tick(); ballsStopped = 1'b1; tick(); tick();
        m_st = S_AIM; m_cur = 1'b0; chk("pass_turn");
        ballsStopped = 1'b0;

        // player 1 climbs to 14 with six correct pots
        shotFired = 1'b1; tick(); m_st = S_ROLL;
        for (int i = 0; i < 6; i++) begin
            increasePoint = 1'b1; correctTarget = (i > 0); tick();
        end
        correctTarget = 1'b1; tick(); m_s1 = 7'd14; m_ntr = 1'b1; chk("build_to_14");
        tick(); m_ntr = 1'b0;
        ballsStopped = 1'b1; tick(); tick(); m_st = S_AIM; chk("below_win_score");
        ballsStopped = 1'b0;

        // winning pot
        shotFired = 1'b1; tick(); m_st = S_ROLL;
        increasePoint = 1'b1; tick();
        correctTarget = 1'b1; tick(); m_s1 = 7'd16; m_ntr = 1'b1; chk("win_award");
        ballsStopped = 1'b1; tick(); m_ntr = 1'b0; m_st = S_SETTLE; chk("win_settle");
        tick(); m_st = S_GO; m_go = 1'b1; m_win = 2'b01; chk("game_over");
        ballsStopped = 1'b0;
        increasePoint = 1'b1; tick(); tick(); chk("game_over_ignores_pot");
        shotFired = 1'b1; tick(); chk("game_over_ignores_shot");
        gameStart = 1'b1; tick(); clear_model(); m_st = S_AIM; chk("restart_clears");

        // reset while a pot is pending
        shotFired = 1'b1; tick(); m_st = S_ROLL;
        increasePoint = 1'b1; tick();
        reset = 1'b1; correctTarget = 1'b1; tick(); clear_model(); chk("reset_mid_pending");
        tick(); chk("no_award_after_reset");

        // saturation at 127 with continuous correct pots
        gameStart = 1'b1; tick(); m_st = S_AIM;
        shotFired = 1'b1; tick(); m_st = S_ROLL;
        for (int i = 0; i < 70; i++) begin
            increasePoint = 1'b1; correctTarget = 1'b1; tick();
        end
        correctTarget = 1'b1; tick(); m_s1 = 7'd127; m_ntr = 1'b1; chk("saturate_127");
        ballsStopped = 1'b1; tick(); m_ntr = 1'b0; m_st = S_SETTLE; chk("saturate_settle");
        tick(); m_st = S_GO; m_go = 1'b1; m_win = 2'b01; chk("saturate_game_over");

        // bounded drain of the scoreboard
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/target_score_keeper.md
TARGET_SCORE_KEEPER -- requirements
Module: target_score_keeper

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 15, meaning the score at or above which a player wins (range 1..127).
REQ-002 The block SHALL have parameter PTS_CORRECT, default 2, meaning the points for a ball pocketed in the correct target pocket.
REQ-003 The block SHALL have parameter PTS_OTHER, default 1, meaning the points for a ball pocketed in any other pocket.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port gameStart, input, 1 bit: single-cycle pulse that starts a new game.
REQ-007 The block SHALL have port shotFired, input, 1 bit: single-cycle pulse when the cue strikes.
REQ-008 The block SHALL have port ballsStopped, input, 1 bit: level, high while all balls are at rest.
REQ-009 The block SHALL have port increasePoint, input, 1 bit: single-cycle pulse, one ball pocketed.
REQ-010 The block SHALL have port correctTarget, input, 1 bit: target-check verdict, valid exactly one cycle after increasePoint.
REQ-011 The block SHALL have port score1, output, 7 bits: player-1 score.
REQ-012 The block SHALL have port score2, output, 7 bits: player-2 score.
REQ-013 The block SHALL have port currentPlayer, output, 1 bit: player whose turn it is (0 = player 1, 1 = player 2).
REQ-014 The block SHALL have port newTargetReq, output, 1 bit: single-cycle pulse requesting target relocation.
REQ-015 The block SHALL have port gameOver, output, 1 bit: level, high while in GAME_OVER.
REQ-016 The block SHALL have port winner, output, 2 bits: 00 none, 01 player 1, 10 player 2.

Function
REQ-017 The FSM SHALL have states IDLE, AIM, ROLL, SETTLE and GAME_OVER.
REQ-018 The FSM SHALL transition as follows:
- IDLE -> AIM on gameStart.
- AIM -> ROLL on shotFired.
- ROLL -> SETTLE when ballsStopped=1 and no pot evaluation is pending in that cycle or the next.
- SETTLE -> AIM (turn decision) or GAME_OVER after one cycle.
- GAME_OVER -> AIM on gameStart.
REQ-019 The block SHALL register increasePoint into potPending, then sample correctTarget in the cycle potPending=1, giving one-cycle scoring latency.
REQ-020 In the potPending=1 cycle, the block SHALL add PTS_CORRECT to the current player's score if correctTarget=1, else PTS_OTHER; the updated score SHALL be visible the following cycle.
REQ-021 The block SHALL assert newTargetReq for exactly one cycle, in the cycle after a PTS_CORRECT award.
REQ-022 The block SHALL set a shotScored flag on any pot during ROLL and clear it on entry to ROLL.
REQ-023 In SETTLE, the block SHALL keep currentPlayer if shotScored=1, otherwise toggle it.
REQ-024 Score arithmetic SHALL be done 8 bits wide and saturate at 127.
REQ-025 If a score is >= WIN_SCORE in SETTLE, the block SHALL go to GAME_OVER and set winner to that player; player 1 is checked first, and ties cannot occur because only one player scores per shot.
REQ-026 The block SHALL score increasePoint in AIM, ROLL and SETTLE, and ignore it (no score, no pending) in IDLE and GAME_OVER.
REQ-027 Back-to-back increasePoint pulses (cycles t, t+1) SHALL each be scored, at t+1 and t+2.
REQ-028 ballsStopped=1 in the same cycle as potPending=1 SHALL delay the exit from ROLL until the award has been applied.
REQ-029 shotFired outside AIM SHALL be ignored.
REQ-030 gameStart in AIM, ROLL or SETTLE SHALL be ignored.
REQ-031 gameStart in GAME_OVER SHALL clear both scores, winner and currentPlayer in the same transition.

Reset
REQ-032 On reset=1 at a clk edge, the block SHALL set state=IDLE, score1=0, score2=0, currentPlayer=0, newTargetReq=0, gameOver=0, winner=00, and clear potPending and shotScored.
REQ-033 Reset SHALL take priority over all other inputs, including mid-shot and mid-pending, and no award SHALL be applied after it.

Verification
REQ-034 The bench SHALL cover a correct pot: gameStart, shotFired, increasePoint@t with correctTarget=1@t+1, then ballsStopped -> score1=2 at t+2, newTargetReq high for one cycle at t+2, currentPlayer stays 0.
REQ-035 The bench SHALL cover a miss: shotFired, ballsStopped with no pot -> SETTLE, then currentPlayer=1, scores unchanged.
REQ-036 The bench SHALL cover a double pot: increasePoint@t and @t+1, correctTarget 0 then 1 -> score +3 total, one newTargetReq pulse.
REQ-037 The bench SHALL cover a win: score1=14, correct pot -> score1=16, then SETTLE -> GAME_OVER, gameOver=1, winner=01, and gameStart -> scores 0, state AIM.
REQ-038 The bench SHALL cover reset mid-pending: increasePoint@t, reset@t+1 -> all outputs at reset values, no score change afterward.
REQ-039 The bench SHALL cover late stop: ballsStopped rising on the potPending cycle -> award applied, and currentPlayer kept after SETTLE.
